// File: rtl/rv32_pkg.sv
// Shared RV32 constants: data width, the canonical NOP and the built-in
// boot program that the instruction store restores on every reset.
package rv32_pkg;

  localparam int XLEN = 32;

  // addi x0,x0,0 -- the canonical RV32 NOP.
  localparam logic [XLEN-1:0] NOP_WORD = 32'h0000_0013;

  localparam int PROG_LEN = 8;

  // Element [0] is word 0 of the program.
  localparam logic [PROG_LEN-1:0][XLEN-1:0] DEFAULT_PROGRAM = {
    32'h0000_2383,  // 7: lw  x7,0(x0)
    32'h0030_2023,  // 6: sw  x3,0(x0)
    32'h0020_E333,  // 5: or  x6,x1,x2
    32'h0020_F2B3,  // 4: and x5,x1,x2
    32'h4020_8233,  // 3: sub x4,x1,x2
    32'h0020_81B3,  // 2: add x3,x1,x2
    32'h00A0_0113,  // 1: addi x2,x0,10
    32'h0050_0093   // 0: addi x1,x0,5
  };

  // Default contents of one word: the boot program, NOP everywhere else.
  function automatic logic [XLEN-1:0] default_word(input int unsigned idx);
    logic [XLEN-1:0] w;
    w = NOP_WORD;
    if (idx < 32'(PROG_LEN)) w = DEFAULT_PROGRAM[idx[2:0]];
    return w;
  endfunction

endpackage

// File: rtl/imem_default_rom.sv
// Constant table of the power-on image for every word of the instruction
// store. Purely combinational; synthesis folds it to tie-offs.
module imem_default_rom
  import rv32_pkg::*;
#(
  parameter int DEPTH = 256
) (
  output logic [DEPTH-1:0][XLEN-1:0] default_image
);

  // Expand the boot program over the full depth, padding with NOPs.
  always_comb begin
    default_image = '0;
    for (int i = 0; i < DEPTH; i++) begin
      default_image[i] = default_word(i[31:0]);
    end
  end

endmodule

// File: rtl/instruction_memory.sv
// Word-addressed RV32 instruction store between the PC register and the
// decoder. Reads are combinational from the byte address; a synchronous
// load port overwrites words. An active-low asynchronous reset restores the
// default program immediately.
//
// Load port: a single-cycle write strobe, no handshake. The word is written
// on the rising clk edge when imem_we=1 and reset=1; there is no
// backpressure and no write-through to the read port.
module instruction_memory
  import rv32_pkg::*;
#(
  parameter int DEPTH = 256
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] pc_address,
  output logic [XLEN-1:0] instruction,
  input  logic            imem_we,
  input  logic [XLEN-1:0] imem_waddr,
  input  logic [XLEN-1:0] imem_wdata
);

  localparam int AW = $clog2(DEPTH);

  logic [DEPTH-1:0][XLEN-1:0] default_image;
  logic [XLEN-1:0]            mem [DEPTH];
  logic                       pc_in_range;
  logic                       waddr_in_range;
  logic [AW-1:0]              rd_idx;
  logic [AW-1:0]              wr_idx;

  // Byte-offset bits are architecturally ignored on both ports.
  logic unused_byte_offsets;
  assign unused_byte_offsets = ^{pc_address[1:0], imem_waddr[1:0]};

  imem_default_rom #(.DEPTH(DEPTH)) u_default_rom (
    .default_image(default_image)
  );

  // An address is mapped only when every bit above the word index is zero,
  // which is the same as addr < 4*DEPTH and prevents aliasing.
  always_comb begin
    pc_in_range    = (pc_address[XLEN-1:AW+2] == '0);
    waddr_in_range = (imem_waddr[XLEN-1:AW+2] == '0);
    rd_idx         = pc_address[AW+1:2];
    wr_idx         = imem_waddr[AW+1:2];
  end

  // Storage: asynchronous restore of the default image, otherwise load port.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= default_image[i];
      end
    end else if (imem_we && waddr_in_range) begin
      mem[wr_idx] <= imem_wdata;
    end
  end

  // Combinational read mux; unmapped addresses fetch a NOP.
  always_comb begin
    instruction = NOP_WORD;
    if (pc_in_range) instruction = mem[rd_idx];
  end

endmodule

// File: tb/tb_instruction_memory.sv
// Self-checking bench for instruction_memory: directed boundary cases plus
// randomized reads/writes against a word-array reference model. Drivers
// push expected words into a queue; a monitor pops and compares them.
module tb_instruction_memory;

  localparam int DEPTH = 256;
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] SPAN = 32'(4 * DEPTH);

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] pc_address = '0;
  logic [31:0] instruction;
  logic        imem_we = 1'b0;
  logic [31:0] imem_waddr = '0;
  logic [31:0] imem_wdata = '0;

  always #5 clk = ~clk;

  instruction_memory #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .pc_address (pc_address),
    .instruction(instruction),
    .imem_we    (imem_we),
    .imem_waddr (imem_waddr),
    .imem_wdata (imem_wdata)
  );

  // ---------------- reference model ----------------
  logic [31:0] boot_prog [8] = '{32'h00500093, 32'h00A00113, 32'h002081B3,
                                 32'h40208233, 32'h0020F2B3, 32'h0020E333,
                                 32'h00302023, 32'h00002383};
  logic [31:0] ref_mem [DEPTH];

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = (i < 8) ? boot_prog[i] : NOP;
  endtask

  function automatic logic [31:0] model_read(input logic [31:0] addr);
    if (addr >= SPAN) return NOP;
    return ref_mem[addr / 4];
  endfunction

  task automatic model_write(input logic [31:0] addr, input logic [31:0] data);
    if (addr < SPAN) ref_mem[addr / 4] = data;
  endtask

  // ---------------- scoreboard ----------------
  logic [31:0] exp_q[$];
  logic [31:0] pc_q[$];
  event        sample_ev;
  int          n_checks = 0;
  int          n_fail   = 0;

  // Monitor: each sample event means the read port has settled for one
  // issued address; compare against the oldest expectation.
  initial begin
    logic [31:0] e;
    logic [31:0] p;
    forever begin
      @(sample_ev);
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        p = pc_q.pop_front();
        n_checks++;
        if (instruction !== e) begin
          n_fail++;
          $display("FAIL read pc=%08h: got %08h expected %08h at %0t",
                   p, instruction, e, $time);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Present an address, let it settle, queue the expected word for the monitor.
  task automatic read_check(input logic [31:0] addr, input logic [31:0] exp);
    pc_address = addr;
    #1;
    exp_q.push_back(exp);
    pc_q.push_back(addr);
    ->sample_ev;
    #1;
  endtask

  task automatic read_model(input logic [31:0] addr);
    read_check(addr, model_read(addr));
  endtask

  // Drive a write from the falling edge, check the old word before the
  // rising edge and the new word after it.
  task automatic write_word(input logic [31:0] addr, input logic [31:0] data);
    @(negedge clk);
    imem_we    = 1'b1;
    imem_waddr = addr;
    imem_wdata = data;
    read_model(addr);
    @(posedge clk);
    #1;
    imem_we = 1'b0;
    if (reset) model_write(addr, data);
    read_model(addr);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    #2;
    reset = 1'b0;
    #5;
    model_reset();
    read_check(32'd0, 32'h00500093);   // visible while still in reset
    reset = 1'b1;

    for (int i = 0; i < 8; i++) begin
      #3;
      read_check(32'(4 * i), boot_prog[i]);
    end
    read_check(32'd2, 32'h00500093);
    read_check(32'd31, 32'h00002383);
    read_check(32'd32, NOP);
    read_check(SPAN - 1, NOP);
    read_check(SPAN, NOP);
    read_check(SPAN + 8, NOP);
    read_check(32'hFFFF_FFFC, NOP);

    // Directed writes
    write_word(32'd8, 32'hDEADBEEF);
    read_check(32'd8, 32'hDEADBEEF);
    write_word(SPAN, 32'h1234_5678);          // dropped, must not alias word 0
    read_check(32'd0, 32'h00500093);
    write_word(SPAN + 4, 32'h8765_4321);      // must not alias word 1
    read_check(32'd4, 32'h00A00113);
    write_word(SPAN - 4, 32'hA5A5_0001);      // last mapped word
    read_check(SPAN - 4, 32'hA5A5_0001);
    write_word(32'd23, 32'h0BAD_F00D);        // misaligned -> word 5
    read_check(32'd20, 32'h0BAD_F00D);

    // Reset mid-cycle with a write pending: reset wins immediately.
    @(negedge clk);
    imem_we    = 1'b1;
    imem_waddr = 32'd8;
    imem_wdata = 32'hCAFE_BABE;
    #1;
    reset = 1'b0;
    model_reset();
    read_check(32'd8, 32'h002081B3);
    read_check(SPAN - 4, NOP);

    // Hold reset low across clock edges with random writes.
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      imem_waddr = 32'(4 * $urandom_range(0, 9));
      imem_wdata = $urandom();
      @(posedge clk);
      #1;
      read_model(imem_waddr);
    end
    @(negedge clk);
    imem_we = 1'b0;
    reset   = 1'b1;
    for (int i = 0; i < 8; i++) read_check(32'(4 * i), boot_prog[i]);

    // Randomized mix of reads and writes.
    for (int i = 0; i < 300; i++) begin
      logic [31:0] a;
      case ($urandom_range(0, 3))
        0:       a = $urandom();
        1:       a = $urandom_range(0, 40);
        default: a = $urandom_range(0, 32'(4 * DEPTH + 32));
      endcase
      if ($urandom_range(0, 2) == 0) write_word(a, $urandom());
      else read_model(a);
    end

    #2;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Watchdog so the run can never hang.
  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/instruction_memory.md
# instruction_memory

Word-addressed RV32 instruction store feeding the fetch stage: the program counter drives `pc_address` and the addressed 32-bit instruction appears combinationally on `instruction`. Contents are a built-in default program, restored on every reset. A synchronous load port lets the bench or boot logic overwrite words. The block sits between the PC register and the decoder.

## Interface
- `DEPTH`, 256: number of 32-bit words; power of two, at least 8.
- `AW`, log2(`DEPTH`): word-index width; derived from `DEPTH`, not overridden.
- `NOP_WORD`, 32'h0000_0013: value returned for unmapped addresses and used to fill unused entries.

- `clk`  in  1  clock; only the load port is sampled on it.
- `reset`  in  1  asynchronous, active-low reset.
- `pc_address`  in  32  byte address from the PC.
- `instruction`  out  32  instruction at `pc_address`; combinational.
- `imem_we`  in  1  load-port write enable.
- `imem_waddr`  in  32  load-port byte address.
- `imem_wdata`  in  32  load-port data word.

## Operation
- Storage is an array of `DEPTH` × 32-bit words.
- Word index is `pc_address[AW+1:2]`.
- `pc_address[1:0]` is ignored, so misaligned addresses read the containing word.
- If `pc_address >= 4*DEPTH`, `instruction` = `NOP_WORD`.
- Default program, words 0–7:
  - 0x00500093 (addi x1,x0,5)
  - 0x00A00113 (addi x2,x0,10)
  - 0x002081B3 (add x3,x1,x2)
  - 0x40208233 (sub x4,x1,x2)
  - 0x0020F2B3 (and x5,x1,x2)
  - 0x0020E333 (or x6,x1,x2)
  - 0x00302023 (sw x3,0(x0))
  - 0x00002383 (lw x7,0(x0))
- Words 8 to `DEPTH`-1 are `NOP_WORD` after reset.
- Reset asserted (`reset`=0): every word is forced to its default value immediately, without waiting for `clk`.
- While `reset` is low:
  - `instruction` reflects the default program.
  - Load-port writes are ignored.
- Load: on rising `clk` with `reset`=1 and `imem_we`=1, word `imem_waddr[AW+1:2]` takes `imem_wdata`.
  - Out-of-range `imem_waddr` (>= 4*`DEPTH`): write dropped, no aliasing.
  - `imem_waddr[1:0]` is ignored.

## Timing
- Read path is purely combinational: `instruction` settles within the same delta/cycle after a `pc_address` change. No clock is needed to read.
- Write latency is 1 `clk` edge.
  - A read of the written address returns the old word before the edge and the new word after it. No write-through bypass.
- Reset assertion takes effect asynchronously; deassertion needs no synchronisation for the read path.
- Reset asserted in the same cycle as a write: reset wins and the word holds its default value.
- `instruction` reset value = the default word at the current `pc_address`. For example, 0x00500093 when `pc_address`=0.
- No X on `instruction` for any `pc_address` value, including before the first `clk` edge, provided `reset` has been pulsed low once.

## Structure
- Shared package `rv32_pkg` holds:
  - `NOP_WORD`
  - the 8-entry default-program constant array
  - the XLEN=32 width constant
- Natural sub-module: `imem_default_rom`, a combinational function/table from word index to default word. The main block uses it for the reset fill.
- The main block contains the array, the reset/load logic and the read mux.

## Test plan
- Pulse `reset` low for 5 ns, then read PC = 0, 4, 8, … 28 with 5 ns settle each -> 00500093, 00A00113, 002081B3, 40208233, 0020F2B3, 0020E333, 00302023, 00002383.
- Read PC = 2 and PC = 31 -> 00500093 and 00002383 (low bits ignored); PC = 32 -> 00000013; PC = 4*`DEPTH` -> 00000013.
- Write 0xDEADBEEF to address 8, reading at PC = 8:
  - before the edge: 002081B3
  - after the edge: DEADBEEF
- Write to address 4*`DEPTH` -> no word changes; PC = 0 still reads 00500093.
- After the 0xDEADBEEF write, assert `reset` low mid-cycle with `imem_we`=1 -> PC = 8 reads 002081B3 immediately, and the write is not applied.
- Hold `reset` low and toggle `clk` with writes -> contents unchanged.
